if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the PC and drives the combinational instruction memory's chip-enable and byte address. Captures the returned word into the IF/ID pipeline register. Handles sequential fetch, branch/jump redirect with MIPS delay-slot semantics, hazard stalls, exception flush and misaligned-fetch detection.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID for bubbles and faults.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hazard unit: hold PC and IF/ID this cycle
branch_taken  input  1  ID stage: redirect fetch after the delay slot
branch_target  input  32  ID stage: redirect byte address
flush  input  1  exception/eret: discard IF/ID and restart at flush_pc
flush_pc  input  32  restart byte address
inst_ce  output  1  instruction memory enable
inst_addr  output  32  instruction memory byte address (= pc)
inst_data  input  32  instruction word, valid in the same cycle as inst_addr
id_pc  output  32  PC of the instruction in IF/ID
id_inst  output  32  instruction word in IF/ID
id_valid  output  1  IF/ID holds a real fetch (bubble = 0)
id_adel  output  1  IF/ID entry is an address-error-on-fetch fault

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset state: pc=RESET_PC, ce_r=0, id_pc=0, id_inst=NOP_WORD, id_valid=0, id_adel=0.
- inst_addr = pc, combinational.
- inst_ce = ce_r & (pc[1:0]==2'b00), combinational. inst_ce is therefore 0 throughout reset and for a misaligned PC.
- ce_r becomes 1 on the first clk edge after rst_n rises and stays 1.
- Next-state priority at each posedge, highest first: flush > stall > ce_r==0 > branch_taken > sequential.
- flush:
  - pc <= flush_pc; ce_r <= 1.
  - IF/ID <= bubble (id_inst=NOP_WORD, id_valid=0, id_adel=0, id_pc=0).
  - Takes precedence over a simultaneous stall or branch_taken.
- stall (no flush): pc and all id_* hold their values; branch_taken is ignored, because the branch stays in ID and is re-presented.
- ce_r==0 (startup cycle): pc holds RESET_PC; IF/ID <= bubble.
- branch_taken: pc <= branch_target.
  - IF/ID captures the current fetch normally; that is the delay-slot instruction at branch PC+4.
  - No flush on branch.
- sequential: pc <= pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- IF/ID capture on an aligned fetch: id_pc=pc, id_inst=inst_data, id_valid=1, id_adel=0.
- IF/ID capture on a misaligned fetch (pc[1:0]!=0):
  - id_pc=pc, id_inst=NOP_WORD, id_valid=1, id_adel=1.
  - pc still advances by the normal rules.
  - Recovery is via a later flush from the exception unit.
- Reset asserted mid-operation immediately forces the reset state, regardless of stall or flush.
- Latency: an instruction presented at inst_addr in cycle N appears on id_* in cycle N+1 unless stalled.
- Single register stage; no combinational path from inst_data to any output other than through IF/ID.

Test Plan:
- Reset/startup: hold rst_n=0 for 3 cycles, then release; memory returns 32'h1111_0000+addr.
  - inst_ce=0 during reset and in the first cycle after release.
  - id_valid=0 until the edge after ce rises.
  - Then id_pc = 0, 4, 8 with id_inst = 32'h1111_0000, 32'h1111_0004, 32'h1111_0008 on consecutive cycles.
- Branch with delay slot: branch_taken=1, branch_target=32'h40 for one cycle while pc=32'h24.
  - id_pc sequence is 0x20, 0x24 (delay slot), 0x40, 0x44.
- Stall during branch: assert stall and branch_taken together for 2 cycles, then branch_taken alone for 1 cycle.
  - pc and id_* frozen for 2 cycles.
  - Redirect to target happens only after stall drops.
- Flush beats stall: at pc=32'h10 assert flush=1, stall=1, flush_pc=32'h180.
  - Next cycle: pc=0x180 and id_valid=0.
  - Following cycle: id_pc=0x180.
- Misaligned target: branch_target=32'h102.
  - inst_ce=0 while pc=0x102.
  - Next cycle: id_adel=1, id_inst=0, id_pc=0x102.
  - Then flush_pc=0x180 recovers fetch cleanly.
- Wrap and async reset: flush to 32'hFFFF_FFFC.
  - The next pc is 0.
  - Dropping rst_n mid-cycle clears id_valid and sets pc=RESET_PC without waiting for clk.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: hazard/redirect controls in, instruction memory
// port out/in, and the IF/ID pipeline register contents out.
interface if_fetch_stage_if;
    // control from hazard unit, ID stage and exception unit
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        flush;
    logic [31:0] flush_pc;
    // instruction memory port
    logic        inst_ce;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    // IF/ID pipeline register
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        id_adel;

    // fetch stage side
    modport master (
        input  stall, branch_taken, branch_target, flush, flush_pc,
        output inst_ce, inst_addr,
        input  inst_data,
        output id_pc, id_inst, id_valid, id_adel
    );

    // surrounding pipeline / memory side
    modport slave (
        output stall, branch_taken, branch_target, flush, flush_pc,
        input  inst_ce, inst_addr,
        output inst_data,
        input  id_pc, id_inst, id_valid, id_adel
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the instruction memory,
// and registers the fetched word into IF/ID. Branches redirect after the
// delay slot; flush restarts fetch; misaligned PCs produce an AdEL entry.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_stage_if.master  bus
);

    logic [31:0] pc_reg,       pc_next;
    logic        ce_reg,       ce_next;
    logic [31:0] id_pc_reg,    id_pc_next;
    logic [31:0] id_inst_reg,  id_inst_next;
    logic        id_valid_reg, id_valid_next;
    logic        id_adel_reg,  id_adel_next;
    logic        pc_aligned;

    assign pc_aligned    = (pc_reg[1:0] == 2'b00);

    // memory is never enabled for a misaligned PC or before startup
    assign bus.inst_addr = pc_reg;
    assign bus.inst_ce   = ce_reg & pc_aligned;

    assign bus.id_pc     = id_pc_reg;
    assign bus.id_inst   = id_inst_reg;
    assign bus.id_valid  = id_valid_reg;
    assign bus.id_adel   = id_adel_reg;

    // next-state selection: flush > stall > startup > branch > sequential
    always_comb begin
        pc_next       = pc_reg;
        ce_next       = ce_reg;
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;
        id_valid_next = id_valid_reg;
        id_adel_next  = id_adel_reg;

        if (bus.flush) begin
            pc_next       = bus.flush_pc;
            ce_next       = 1'b1;
            id_pc_next    = 32'h0;
            id_inst_next  = NOP_WORD;
            id_valid_next = 1'b0;
            id_adel_next  = 1'b0;
        end else if (bus.stall) begin
            // hold everything; a pending branch stays in ID and is re-presented
        end else if (!ce_reg) begin
            // startup cycle: enable fetch, PC stays at the reset vector
            ce_next       = 1'b1;
            pc_next       = RESET_PC;
            id_pc_next    = 32'h0;
            id_inst_next  = NOP_WORD;
            id_valid_next = 1'b0;
            id_adel_next  = 1'b0;
        end else begin
            // the word fetched now is captured even on a branch (delay slot)
            id_pc_next    = pc_reg;
            id_valid_next = 1'b1;
            if (pc_aligned) begin
                id_inst_next = bus.inst_data;
                id_adel_next = 1'b0;
            end else begin
                id_inst_next = NOP_WORD;
                id_adel_next = 1'b1;
            end
            pc_next = bus.branch_taken ? bus.branch_target : (pc_reg + 32'd4);
        end
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg       <= RESET_PC;
            ce_reg       <= 1'b0;
            id_pc_reg    <= 32'h0;
            id_inst_reg  <= NOP_WORD;
            id_valid_reg <= 1'b0;
            id_adel_reg  <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            ce_reg       <= ce_next;
            id_pc_reg    <= id_pc_next;
            id_inst_reg  <= id_inst_next;
            id_valid_reg <= id_valid_next;
            id_adel_reg  <= id_adel_next;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: startup, delay-slot branch, stalled
// branch, flush priority, misaligned fetch, PC wrap and async reset.
module tb_if_fetch_stage;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    if_fetch_stage_if bus();

    if_fetch_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_WORD(32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // combinational instruction memory: word = 0x1111_0000 + address
    assign bus.inst_data = 32'h1111_0000 + bus.inst_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.stall         = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.branch_target = 32'h0;
        bus.flush         = 1'b0;
        bus.flush_pc      = 32'h0;

        // reset held for 3 cycles
        repeat (3) tick();
        chk("rst_ce",    {31'b0, bus.inst_ce},  32'h0);
        chk("rst_addr",  bus.inst_addr,         32'h0);
        chk("rst_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("rst_idpc",  bus.id_pc,             32'h0);
        chk("rst_inst",  bus.id_inst,           32'h0);
        chk("rst_adel",  {31'b0, bus.id_adel},  32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_ce0",   {31'b0, bus.inst_ce},  32'h0);

        // startup edge: ce rises, IF/ID still a bubble
        tick();
        chk("st_ce1",    {31'b0, bus.inst_ce},  32'h1);
        chk("st_addr",   bus.inst_addr,         32'h0);
        chk("st_valid",  {31'b0, bus.id_valid}, 32'h0);

        // sequential fetch 0, 4, 8
        for (int i = 0; i < 3; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            tick();
            chk("seq_valid", {31'b0, bus.id_valid}, 32'h1);
            chk("seq_pc",    bus.id_pc,             a);
            chk("seq_inst",  bus.id_inst,           32'h1111_0000 + a);
        end

        // run to pc=0x24
        repeat (6) tick();
        chk("pre_br_pc",   bus.inst_addr, 32'h24);
        chk("pre_br_idpc", bus.id_pc,     32'h20);

        // branch at pc=0x24 to 0x40: delay slot 0x24 then 0x40, 0x44
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h40;
        tick();
        bus.branch_taken  = 1'b0;
        chk("br_slot",   bus.id_pc,     32'h24);
        chk("br_pc",     bus.inst_addr, 32'h40);
        tick();
        chk("br_tgt",    bus.id_pc,     32'h40);
        chk("br_tinst",  bus.id_inst,   32'h1111_0040);
        tick();
        chk("br_tgt4",   bus.id_pc,     32'h44);

        // stall together with branch for two cycles: everything frozen
        bus.stall         = 1'b1;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h80;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stl_pc",    bus.inst_addr,         32'h48);
            chk("stl_idpc",  bus.id_pc,             32'h44);
            chk("stl_valid", {31'b0, bus.id_valid}, 32'h1);
        end
        bus.stall = 1'b0;
        tick();
        bus.branch_taken = 1'b0;
        chk("stl_slot",  bus.id_pc,     32'h48);
        chk("stl_redir", bus.inst_addr, 32'h80);
        tick();
        chk("stl_tgt",   bus.id_pc,     32'h80);

        // move to pc=0x10, then flush+stall together
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h10;
        tick();
        chk("fl0_pc",    bus.inst_addr, 32'h10);
        bus.stall    = 1'b1;
        bus.flush_pc = 32'h180;
        tick();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        chk("fl_pc",     bus.inst_addr,         32'h180);
        chk("fl_valid",  {31'b0, bus.id_valid}, 32'h0);
        chk("fl_idpc",   bus.id_pc,             32'h0);
        chk("fl_inst",   bus.id_inst,           32'h0);
        tick();
        chk("fl_next",   bus.id_pc,             32'h180);
        chk("fl_ninst",  bus.id_inst,           32'h1111_0180);
        chk("fl_nvalid", {31'b0, bus.id_valid}, 32'h1);

        // misaligned branch target
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h102;
        tick();
        bus.branch_taken = 1'b0;
        chk("mis_addr",  bus.inst_addr,         32'h102);
        chk("mis_ce",    {31'b0, bus.inst_ce},  32'h0);
        tick();
        chk("mis_adel",  {31'b0, bus.id_adel},  32'h1);
        chk("mis_inst",  bus.id_inst,           32'h0);
        chk("mis_idpc",  bus.id_pc,             32'h102);
        chk("mis_valid", {31'b0, bus.id_valid}, 32'h1);
        chk("mis_adv",   bus.inst_addr,         32'h106);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h180;
        tick();
        bus.flush = 1'b0;
        chk("rec_ce",    {31'b0, bus.inst_ce},  32'h1);
        chk("rec_adel",  {31'b0, bus.id_adel},  32'h0);
        tick();
        chk("rec_idpc",  bus.id_pc,             32'h180);
        chk("rec_adel2", {31'b0, bus.id_adel},  32'h0);

        // wrap: 0xFFFF_FFFC -> 0
        bus.flush    = 1'b1;
        bus.flush_pc = 32'hFFFF_FFFC;
        tick();
        bus.flush = 1'b0;
        chk("wr_pc",     bus.inst_addr, 32'hFFFF_FFFC);
        tick();
        chk("wr_zero",   bus.inst_addr, 32'h0);
        chk("wr_idpc",   bus.id_pc,     32'hFFFF_FFFC);
        chk("wr_inst",   bus.id_inst,   32'h1110_FFFC);
        tick();
        chk("wr_pc4",    bus.inst_addr, 32'h4);

        // asynchronous reset mid-cycle with stall and flush active
        bus.stall    = 1'b1;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h200;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_pc",     bus.inst_addr,         32'h0);
        chk("ar_valid",  {31'b0, bus.id_valid}, 32'h0);
        chk("ar_ce",     {31'b0, bus.inst_ce},  32'h0);
        chk("ar_idpc",   bus.id_pc,             32'h0);
        tick();
        chk("ar_hold",   bus.inst_addr,         32'h0);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        rst_n     = 1'b1;
        tick();
        chk("ar_rel_ce", {31'b0, bus.inst_ce},  32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
